// File: rtl/requant_relu_8.sv
// Requantization stage: per-lane bias, fixed-point scale, rounding shift,
// optional ReLU and int8 saturation over one ROWS-beat frame.
module requant_relu_8 #(
   parameter int LANES  = 8,
   parameter int ROWS   = 8,
   parameter int ACC_W  = 32,
   parameter int MULT_W = 16,
   parameter int OUT_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic                    ready,
   output logic                    done,
   input  logic signed [ACC_W-1:0] cfg_bias [LANES],
   input  logic [MULT_W-1:0]       cfg_mult,
   input  logic [4:0]              cfg_shift,
   input  logic                    cfg_relu,
   input  logic                    c_valid,
   output logic                    c_ready,
   input  logic signed [ACC_W-1:0] c_in [LANES],
   output logic                    q_valid,
   input  logic                    q_ready,
   output logic signed [OUT_W-1:0] q_out [LANES],
   output logic                    q_last
);

   localparam int SW = ACC_W + 1;
   localparam int PW = ACC_W + MULT_W + 2;
   localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                  r_state, w_state_nx;
   logic [CW-1:0]           r_row;
   logic signed [ACC_W-1:0] r_bias [LANES];
   logic [MULT_W-1:0]       r_mult;
   logic [4:0]              r_shift;
   logic                    r_relu;

   logic                    r_v1, r_v2, r_v3, r_l1, r_l2, r_l3;
   logic signed [SW-1:0]    r_s1 [LANES];
   logic signed [PW-1:0]    r_s2 [LANES];
   logic signed [PW-1:0]    r_s3 [LANES];
   logic                    r_q_valid, r_q_last, r_done;
   logic signed [OUT_W-1:0] r_q_out [LANES];

   logic                    w_en, w_c_ready, w_ready, w_c_fire, w_q_fire, w_start, w_row_last;
   logic signed [PW-1:0]    w_inc;
   logic signed [SW-1:0]    w_s1 [LANES];
   logic signed [PW-1:0]    w_s2 [LANES];
   logic signed [PW-1:0]    w_sum [LANES];
   logic signed [PW-1:0]    w_s3 [LANES];
   logic signed [OUT_W-1:0] w_q [LANES];

   assign w_en       = !r_q_valid | q_ready;
   assign w_c_fire   = c_valid & w_c_ready;
   assign w_q_fire   = r_q_valid & q_ready;
   assign w_start    = start & (r_state == IDLE);
   assign w_row_last = (r_row == CW'(ROWS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nx = RUN;
         RUN:     if (w_c_fire && w_row_last) w_state_nx = DRAIN;
         DRAIN:   if (w_q_fire && r_q_last) w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   always_comb begin
      w_ready   = (r_state == IDLE);
      w_c_ready = (r_state == RUN) & w_en;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row   <= '0;
         r_mult  <= '0;
         r_shift <= '0;
         r_relu  <= 1'b0;
         for (int unsigned i = 0; i < LANES; i++) r_bias[i] <= '0;
      end else if (w_start) begin
         r_row   <= '0;
         r_mult  <= cfg_mult;
         r_shift <= cfg_shift;
         r_relu  <= cfg_relu;
         for (int unsigned i = 0; i < LANES; i++) r_bias[i] <= cfg_bias[i];
      end else if (w_c_fire) begin
         r_row <= r_row + CW'(1);
      end
   end

   // Datapath: S1 sum, S2 product, S3 rounded shift, then ReLU/saturate into q.
   always_comb begin
      w_inc = '0;
      if (r_shift != 5'd0) w_inc = PW'(1) << (r_shift - 5'd1);
      for (int unsigned i = 0; i < LANES; i++) begin
         w_s1[i]  = SW'(c_in[i]) + SW'(r_bias[i]);
         w_s2[i]  = PW'(r_s1[i]) * PW'($signed({1'b0, r_mult}));
         w_sum[i] = r_s2[i] + w_inc;
         w_s3[i]  = w_sum[i] >>> r_shift;
         if (r_relu && r_s3[i][PW-1])
            w_q[i] = '0;
         else if ((&r_s3[i][PW-1:OUT_W-1]) || !(|r_s3[i][PW-1:OUT_W-1]))
            w_q[i] = r_s3[i][OUT_W-1:0];
         else if (r_s3[i][PW-1])
            w_q[i] = {1'b1, {(OUT_W-1){1'b0}}};
         else
            w_q[i] = {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {r_v1, r_v2, r_v3, r_l1, r_l2, r_l3} <= '0;
         r_q_valid <= 1'b0;
         r_q_last  <= 1'b0;
         for (int unsigned i = 0; i < LANES; i++) begin
            r_s1[i]    <= '0;
            r_s2[i]    <= '0;
            r_s3[i]    <= '0;
            r_q_out[i] <= '0;
         end
      end else if (w_en) begin
         r_v1      <= w_c_fire;
         r_l1      <= w_row_last;
         r_v2      <= r_v1;
         r_l2      <= r_l1;
         r_v3      <= r_v2;
         r_l3      <= r_l2;
         r_q_valid <= r_v3;
         r_q_last  <= r_v3 & r_l3;
         for (int unsigned i = 0; i < LANES; i++) begin
            r_s1[i]    <= w_s1[i];
            r_s2[i]    <= w_s2[i];
            r_s3[i]    <= w_s3[i];
            r_q_out[i] <= w_q[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_done <= 1'b0;
      else     r_done <= w_q_fire & r_q_last;
   end

   assign ready   = w_ready;
   assign c_ready = w_c_ready;
   assign q_valid = r_q_valid;
   assign q_last  = r_q_last;
   assign q_out   = r_q_out;
   assign done    = r_done;

endmodule

// File: tb/tb_requant_relu_8.sv
// Bench for requant_relu_8: directed vector table, random frames against an
// arithmetic reference model, backpressure, frame control and mid-frame reset.
module tb_requant_relu_8;

   localparam int L = 8;
   localparam int R = 8;

   logic               clk = 1'b0;
   logic               rst, start, cfg_relu, c_valid, q_ready;
   logic               ready, done, c_ready, q_valid, q_last;
   logic signed [31:0] cfg_bias [L];
   logic        [15:0] cfg_mult;
   logic        [4:0]  cfg_shift;
   logic signed [31:0] c_in [L];
   logic signed [7:0]  q_out [L];

   always #5 clk = ~clk;

   requant_relu_8 #(.LANES(L), .ROWS(R), .ACC_W(32), .MULT_W(16), .OUT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .ready(ready), .done(done),
      .cfg_bias(cfg_bias), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
      .c_valid(c_valid), .c_ready(c_ready), .c_in(c_in),
      .q_valid(q_valid), .q_ready(q_ready), .q_out(q_out), .q_last(q_last)
   );

   typedef struct packed {
      logic [L-1:0][31:0] bias;
      logic [15:0]        mult;
      logic [4:0]         shift;
      logic               relu;
      logic [L-1:0][31:0] cin;
      logic [L-1:0][7:0]  exp;
   } vec_t;

   vec_t               vt [7];
   int                 n_cmp = 0;
   int                 n_bad = 0;
   logic [L-1:0][31:0] f_bias;
   logic [15:0]        f_mult;
   logic [4:0]         f_shift;
   logic               f_relu;
   logic [L-1:0][31:0] f_rows [R];
   logic [L-1:0][7:0]  f_exp [R];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] q_row();
      logic [63:0] v;
      for (int i = 0; i < L; i++) v[i*8 +: 8] = q_out[i];
      return v;
   endfunction

   function automatic logic [L-1:0][31:0] p32(input int a0, a1, a2, a3, a4, a5, a6, a7);
      logic [L-1:0][31:0] v;
      v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
      v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
      return v;
   endfunction

   function automatic logic [L-1:0][7:0] p8(input int a0, a1, a2, a3, a4, a5, a6, a7);
      logic [L-1:0][7:0] v;
      v[0] = a0[7:0]; v[1] = a1[7:0]; v[2] = a2[7:0]; v[3] = a3[7:0];
      v[4] = a4[7:0]; v[5] = a5[7:0]; v[6] = a6[7:0]; v[7] = a7[7:0];
      return v;
   endfunction

   // floor((x*m + half) / 2^sh), then ReLU and clamp to int8
   function automatic logic [7:0] model(input logic [31:0] c, input logic [31:0] b,
                                        input logic [15:0] m, input logic [4:0] sh, input logic relu);
      longint num, d, q;
      d   = longint'(1) << sh;
      num = (longint'($signed(c)) + longint'($signed(b))) * longint'(m) + d / 2;
      q   = num / d;
      if (num < 0 && q * d != num) q = q - 1;
      if (relu && q < 0) q = 0;
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
      return q[7:0];
   endfunction

   function automatic logic [31:0] rv();
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return 32'($urandom_range(0, 600)) - 32'd300;
         2:       return 32'($urandom_range(0, 140000)) - 32'd70000;
         default: return ($urandom_range(0, 1) != 0) ? 32'h7fffffff : 32'h80000000;
      endcase
   endfunction

   task automatic rand_frame();
      for (int i = 0; i < L; i++) f_bias[i] = 32'($urandom_range(0, 400)) - 32'd200;
      f_mult  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 8));
      f_shift = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      f_relu  = 1'($urandom_range(0, 1));
      for (int r = 0; r < R; r++)
         for (int i = 0; i < L; i++) begin
            f_rows[r][i] = rv();
            f_exp[r][i]  = model(f_rows[r][i], f_bias[i], f_mult, f_shift, f_relu);
         end
   endtask

   task automatic load_vec(input int k);
      f_bias = vt[k].bias; f_mult = vt[k].mult; f_shift = vt[k].shift; f_relu = vt[k].relu;
      for (int r = 0; r < R; r++) begin
         f_rows[r] = vt[k].cin;
         f_exp[r]  = vt[k].exp;
      end
   endtask

   task automatic apply_cfg(input logic garbage);
      for (int i = 0; i < L; i++) cfg_bias[i] = garbage ? $urandom : f_bias[i];
      cfg_mult  = garbage ? 16'($urandom) : f_mult;
      cfg_shift = garbage ? 5'($urandom)  : f_shift;
      cfg_relu  = garbage ? 1'($urandom)  : f_relu;
   endtask

   // Runs one frame from a negedge; returns in the done cycle so a following
   // frame's start lands in that cycle.
   task automatic run_frame(input int qmode, input bit hold, input string tag);
      int in_i, out_i, fire0, fv;
      bit done_nx, got_done;
      in_i = 0; out_i = 0; fire0 = -1; fv = -1; done_nx = 0; got_done = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (done_nx) begin
            chk({tag, " done pulse"}, 64'(done), 64'd1);
            chk({tag, " ready at done"}, 64'(ready), 64'd1);
            chk({tag, " q_valid at done"}, 64'(q_valid), 64'd0);
            got_done = 1;
            start = 0; c_valid = 0;
            break;
         end
         if (cyc == 0) begin
            chk({tag, " ready before start"}, 64'(ready), 64'd1);
            start = 1;
            apply_cfg(1'b0);
         end else begin
            chk({tag, " done early"}, 64'(done), 64'd0);
            chk({tag, " ready busy"}, 64'(ready), 64'd0);
            start = hold && (in_i < R);
            if (hold) apply_cfg(1'b1);
         end
         c_valid = (in_i < R);
         if (in_i < R)
            for (int i = 0; i < L; i++) c_in[i] = f_rows[in_i][i];
         case (qmode)
            0:       q_ready = 1;
            1:       q_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: q_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (q_valid && !q_ready) chk({tag, " c_ready stall"}, 64'(c_ready), 64'd0);
         if (qmode == 0 && fv < 0 && q_valid) begin
            fv = cyc;
            chk({tag, " latency"}, 64'(fv - fire0), 64'd4);
         end
         if (c_valid && c_ready) begin
            if (fire0 < 0) fire0 = cyc;
            in_i++;
         end
         if (q_valid && q_ready) begin
            if (out_i < R) begin
               chk($sformatf("%s row%0d q_out", tag, out_i), q_row(), 64'(f_exp[out_i]));
               chk($sformatf("%s row%0d q_last", tag, out_i), 64'(q_last), 64'(out_i == R - 1));
               if (out_i == R - 1) done_nx = 1;
            end else begin
               chk({tag, " extra beat"}, 64'd1, 64'd0);
            end
            out_i++;
         end
         @(negedge clk);
      end
      if (!got_done) begin
         n_cmp++; n_bad++;
         $display("FAIL %s timeout: got %0d rows expected %0d", tag, out_i, R);
      end
   endtask

   initial begin
      int acc;
      vt[0] = '{bias: p32(0,0,0,0,0,0,0,0), mult: 16'd1, shift: 5'd0, relu: 1'b0,
                cin: p32(5,-3,127,128,-128,-129,0,1000), exp: p8(5,-3,127,127,-128,-128,0,127)};
      vt[1] = '{bias: p32(0,0,0,0,0,0,0,0), mult: 16'd1, shift: 5'd2, relu: 1'b0,
                cin: p32(6,5,-6,-7,2,-2,1,-1), exp: p8(2,1,-1,-2,1,0,0,0)};
      vt[2] = '{bias: p32(100,100,100,100,100,100,100,100), mult: 16'd3, shift: 5'd1, relu: 1'b0,
                cin: p32(10,10,10,10,10,10,10,10), exp: p8(127,127,127,127,127,127,127,127)};
      vt[3] = '{bias: p32(0,0,0,0,0,0,0,0), mult: 16'd3, shift: 5'd1, relu: 1'b0,
                cin: p32(7,7,7,7,7,7,7,7), exp: p8(11,11,11,11,11,11,11,11)};
      vt[4] = '{bias: p32(0,0,0,0,0,0,0,0), mult: 16'd1, shift: 5'd0, relu: 1'b1,
                cin: p32(-200,-200,-200,-200,-200,-200,-200,-200), exp: p8(0,0,0,0,0,0,0,0)};
      vt[5] = '{bias: p32(0,0,0,0,0,0,0,0), mult: 16'd1, shift: 5'd0, relu: 1'b0,
                cin: p32(-200,-200,-200,-200,-200,-200,-200,-200), exp: p8(-128,-128,-128,-128,-128,-128,-128,-128)};
      vt[6] = '{bias: p32(0,0,0,0,0,0,0,0), mult: 16'hffff, shift: 5'd31, relu: 1'b0,
                cin: p32(32'h7fffffff,32'h80000000,32768,-32768,0,1,100000,-100000),
                exp: p8(127,-128,1,-1,0,0,3,-3)};

      rst = 1; start = 0; c_valid = 0; q_ready = 0;
      f_bias = '0; f_mult = '0; f_shift = '0; f_relu = 0;
      apply_cfg(1'b0);
      for (int i = 0; i < L; i++) c_in[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst ready", 64'(ready), 64'd1);
      chk("rst c_ready", 64'(c_ready), 64'd0);
      chk("rst q_valid", 64'(q_valid), 64'd0);
      chk("rst q_last", 64'(q_last), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst q_out", q_row(), 64'd0);
      rst = 0;
      @(negedge clk);

      for (int k = 0; k < 7; k++) begin
         load_vec(k);
         run_frame(0, 0, $sformatf("vec%0d", k));
      end

      rand_frame();
      run_frame(1, 0, "bp1001");
      rand_frame();
      run_frame(0, 1, "hold_start");

      // Reset after four accepted rows; a full frame must then run cleanly.
      rand_frame();
      @(negedge clk);
      start = 1; apply_cfg(1'b0); c_valid = 1; q_ready = 1; acc = 0;
      for (int i = 0; i < L; i++) c_in[i] = f_rows[0][i];
      for (int cyc = 0; cyc < 40 && acc < 4; cyc++) begin
         #1;
         if (c_valid && c_ready) acc++;
         @(negedge clk);
         start = 0;
         if (acc < R) for (int i = 0; i < L; i++) c_in[i] = f_rows[acc][i];
      end
      chk("midrst rows accepted", 64'(acc), 64'd4);
      #1;
      chk("midrst q_valid before", 64'(q_valid), 64'd1);
      #1 rst = 1;
      #1;
      chk("midrst q_valid", 64'(q_valid), 64'd0);
      chk("midrst c_ready", 64'(c_ready), 64'd0);
      chk("midrst done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 0; c_valid = 0;
      #1;
      chk("midrst ready after", 64'(ready), 64'd1);
      @(negedge clk);
      run_frame(0, 0, "post_rst");

      for (int k = 0; k < 10; k++) begin
         rand_frame();
         run_frame((k % 2 == 0) ? 2 : 0, 0, $sformatf("rand%0d", k));
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
